// File: rtl/ifu_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, reset PC and the
// entry format carried from memory to decode.
package ifu_fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
    logic                    fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO of fetch entries toward decode. Flush wins over push/pop;
// a pop makes room for a push in the same cycle even when full.
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_entry,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding imem read at a time, results buffered
// toward decode, with redirect flushing and dropping stale responses.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int DATA_W     = FETCH_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              redirect,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_req_pc;

  logic              w_outstanding;
  logic [CNT_W:0]    w_occupancy;
  logic              w_slot_free;
  logic              w_aligned;
  logic              w_in_req;
  logic              w_hs;
  logic              w_misalign;
  logic              w_resp_push;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  // A request reserves a buffer slot from issue until its response lands.
  assign w_outstanding = (r_state == ST_WAIT) || (r_state == ST_DROP);
  assign w_occupancy   = {1'b0, w_count} + {{CNT_W{1'b0}}, w_outstanding};
  assign w_slot_free   = (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign w_aligned     = (pc[1:0] == 2'b00);
  assign w_in_req      = !rst && (r_state == ST_REQ);

  assign imem_req_valid = w_in_req && w_slot_free && w_aligned && !redirect;
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign w_hs           = imem_req_valid && imem_req_ready;
  assign pc_advance     = w_hs;

  assign w_misalign  = w_in_req && w_slot_free && !w_aligned && !redirect;
  assign w_resp_push = !rst && (r_state == ST_WAIT) && imem_resp_valid;
  assign w_push      = w_resp_push || w_misalign;
  assign w_pop       = inst_valid && inst_ready;

  always_comb begin
    w_push_entry = '{pc: r_req_pc, data: imem_resp_data, fault: imem_resp_err};
    if (w_misalign) w_push_entry = '{pc: pc, data: '0, fault: 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else if (redirect) begin
      // A response still in flight must be swallowed before fetching the target.
      r_state <= (w_outstanding && !imem_resp_valid) ? ST_DROP : ST_REQ;
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (w_hs)            r_state <= ST_WAIT;
          else if (w_misalign) r_state <= ST_HALT;
        end
        ST_WAIT, ST_DROP: begin
          if (imem_resp_valid) r_state <= ST_REQ;
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_req_pc <= pc;
  end

  ifu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  assign inst_valid = !w_empty;
  assign inst_data  = w_head.data;
  assign inst_pc    = w_head.pc;
  assign inst_fault = w_head.fault;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a PC generator and imem model surround the
// DUT; expected requests and instructions are queued and checked by a monitor.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = RESET_PC;
  logic        pc_advance;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_entry_t exp_inst[$];
  logic [31:0]  exp_req[$];

  int          mem_lat  = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        mpend    = 1'b0;
  logic [31:0] maddr    = '0;
  int          mcnt     = 0;

  ifu_fetch #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_advance      (pc_advance),
    .redirect        (redirect),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  // PC generator
  always @(posedge clk) begin
    if (rst)             pc <= RESET_PC;
    else if (redirect)   pc <= target;
    else if (pc_advance) pc <= pc + 32'd4;
  end

  // Instruction memory: response mem_lat cycles after the accept cycle + 1
  always @(posedge clk) begin
    imem_resp_valid <= 1'b0;
    imem_resp_err   <= 1'b0;
    if (mpend) begin
      if (mcnt == 0) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= mem_word(maddr);
        imem_resp_err   <= (maddr == err_addr);
        mpend           <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      if (mem_lat == 0) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= mem_word(imem_req_addr);
        imem_resp_err   <= (imem_req_addr == err_addr);
      end else begin
        mpend <= 1'b1;
        maddr <= imem_req_addr;
        mcnt  <= mem_lat - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_inst(input logic [31:0] p, input logic [31:0] d, input logic f);
    fetch_entry_t e;
    e.pc = p;
    e.data = d;
    e.fault = f;
    exp_inst.push_back(e);
  endtask

  // Waits for a request handshake at address a, returns just after its accept edge.
  task automatic wait_hs(input logic [31:0] a);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && imem_req_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL hs_timeout: no request at 0x%0h, expected one within 60 cycles", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_req_valid"},  64'(imem_req_valid), 64'd0);
    chk({tag, "_pc_advance"}, 64'(pc_advance),     64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid),     64'd0);
    chk({tag, "_inst_fault"}, 64'(inst_fault),     64'd0);
    chk({tag, "_inst_data"},  64'(inst_data),      64'd0);
    chk({tag, "_inst_pc"},    64'(inst_pc),        64'd0);
    chk({tag, "_req_addr"},   64'(imem_req_addr),  64'd0);
  endtask

  // Monitor: request addresses, pc_advance pulses and delivered instructions
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got request at 0x%0h, expected none", imem_req_addr);
        end else begin
          chk("req_addr", 64'(imem_req_addr), 64'(exp_req.pop_front()));
        end
      end
      chk("pc_advance", 64'(pc_advance), 64'(imem_req_valid && imem_req_ready));
      if (inst_valid && inst_ready) begin
        if (exp_inst.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_inst: got inst pc 0x%0h, expected none", inst_pc);
        end else begin
          e = exp_inst.pop_front();
          chk("inst_pc",    64'(inst_pc),    64'(e.pc));
          chk("inst_data",  64'(inst_data),  64'(e.data));
          chk("inst_fault", 64'(inst_fault), 64'(e.fault));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and zero-wait streaming, error response at 0x80000008
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    err_addr = 32'h8000_0008;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0008);
    push_inst(32'h8000_0000, 32'h0000_0013, 1'b0);
    push_inst(32'h8000_0004, 32'h0040_0013, 1'b0);
    push_inst(32'h8000_0008, 32'h0080_0013, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr",  64'(imem_req_addr),  64'h8000_0000);
    @(posedge clk);
    #1;
    wait_hs(32'h8000_0008);
    imem_req_ready = 1'b0;
    cyc(6);

    // Decode stall with a 2-entry buffer, then drain and resume
    exp_req.push_back(32'h8000_000C);
    exp_req.push_back(32'h8000_0010);
    exp_req.push_back(32'h8000_0014);
    push_inst(32'h8000_000C, 32'h00C0_0013, 1'b0);
    push_inst(32'h8000_0010, 32'h0100_0013, 1'b0);
    push_inst(32'h8000_0014, 32'h0140_0013, 1'b0);
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    cyc(10);
    @(negedge clk);
    chk("stall_req_valid",  64'(imem_req_valid), 64'd0);
    chk("stall_pc_advance", 64'(pc_advance),     64'd0);
    chk("stall_inst_valid", 64'(inst_valid),     64'd1);
    chk("stall_head_pc",    64'(inst_pc),        64'h8000_000C);
    chk("stall_head_data",  64'(inst_data),      64'h00C0_0013);
    chk("stall_pc_held",    64'(pc),             64'h8000_0014);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    cyc(4);
    imem_req_ready = 1'b1;
    wait_hs(32'h8000_0014);
    imem_req_ready = 1'b0;
    cyc(6);

    // Redirect while waiting on a slow response: the stale response is dropped
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    mem_lat = 2;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0100);
    push_inst(32'h8000_0000, 32'h0000_0013, 1'b0);
    push_inst(32'h8000_0100, 32'h1000_0013, 1'b0);
    imem_req_ready = 1'b1;
    wait_hs(32'h8000_0004);
    redirect = 1'b1;
    target = 32'h8000_0100;
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("drop_inst_valid", 64'(inst_valid),     64'd0);
    chk("drop_req_valid",  64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    wait_hs(32'h8000_0100);
    imem_req_ready = 1'b0;
    mem_lat = 0;
    cyc(8);

    // Redirect in the cycle a request would be accepted, with a buffered entry
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0200);
    push_inst(32'h8000_0200, 32'h2000_0013, 1'b0);
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    wait_hs(32'h8000_0000);
    cyc(1);
    redirect = 1'b1;
    target = 32'h8000_0200;
    @(negedge clk);
    chk("redir_req_valid",  64'(imem_req_valid), 64'd0);
    chk("redir_pc_advance", 64'(pc_advance),     64'd0);
    chk("redir_pre_flush",  64'(inst_valid),     64'd1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("flushed_inst_valid", 64'(inst_valid),     64'd0);
    chk("target_req_valid",   64'(imem_req_valid), 64'd1);
    chk("target_req_addr",    64'(imem_req_addr),  64'h8000_0200);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    cyc(6);

    // Misaligned PC: fault entry, then halt until the next redirect
    push_inst(32'h8000_0102, 32'h0000_0000, 1'b1);
    target = 32'h8000_0102;
    redirect = 1'b1;
    cyc(1);
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("misalign_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    cyc(5);
    @(negedge clk);
    chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
    chk("halt_pc_held",   64'(pc),             64'h8000_0102);
    @(posedge clk);
    #1;
    exp_req.push_back(32'h8000_0300);
    push_inst(32'h8000_0300, 32'h3000_0013, 1'b0);
    target = 32'h8000_0300;
    redirect = 1'b1;
    cyc(1);
    redirect = 1'b0;
    wait_hs(32'h8000_0300);
    imem_req_ready = 1'b0;
    cyc(6);

    // Reset while waiting; the late response must not be buffered
    exp_req.push_back(32'h8000_0304);
    mem_lat = 2;
    imem_req_ready = 1'b1;
    wait_hs(32'h8000_0304);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    cyc(1);
    check_reset_outputs("rst_wait");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 0;
    cyc(2);
    @(negedge clk);
    chk("stale_inst_valid", 64'(inst_valid), 64'd0);
    @(posedge clk);
    #1;
    exp_req.push_back(32'h8000_0000);
    push_inst(32'h8000_0000, 32'h0000_0013, 1'b0);
    imem_req_ready = 1'b1;
    wait_hs(32'h8000_0000);
    imem_req_ready = 1'b0;
    cyc(6);

    chk("exp_req_left",  64'(exp_req.size()),  64'd0);
    chk("exp_inst_left", 64'(exp_inst.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch stage that consumes the program counter and issues instruction-memory reads at that address. It returns each fetched instruction, tagged with its PC, to decode through a valid/ready interface. It tells the PC generator when to step (pc_advance). When a jump is taken (redirect), it discards all stale fetch state.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
FIFO_DEPTH, 2, entries in the instruction buffer toward decode (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pc  in  ADDR_W  current PC from PC generator
pc_advance  out  1  1-cycle pulse; PC generator steps pc+4 on the next edge
redirect  in  1  jump taken this cycle; PC loads the jump target on the next edge
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  read address (= pc while requesting)
imem_resp_valid  in  1  read data valid, 1 cycle, no backpressure
imem_resp_data  in  DATA_W  read data
imem_resp_err  in  1  access fault for this response
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode consumes head
inst_data  out  DATA_W  instruction
inst_pc  out  ADDR_W  PC of instruction
inst_fault  out  1  instruction carries a fetch fault

Behaviour:
- Reset (sync, active-high): state=REQ, buffer empty, outstanding=0. All outputs 0: imem_req_valid, pc_advance, inst_valid, inst_fault, inst_data, inst_pc, imem_req_addr.
- At most one outstanding request. A request is issued only if buffer occupancy plus outstanding is less than FIFO_DEPTH.
- States: REQ, WAIT, DROP, HALT.
- REQ: imem_req_valid = slot free && pc[1:0]==0 && !redirect. imem_req_addr = pc.
  - On handshake (valid&&ready): latch req_pc=pc, pulse pc_advance in the same cycle, go to WAIT.
  - If pc[1:0]!=0 and a slot is free: push {pc, 0, fault=1}, no request, no pc_advance, go to HALT.
- WAIT: on imem_resp_valid, push {req_pc, imem_resp_data, imem_resp_err}, go to REQ. An error response does not stop fetching.
- DROP: the next imem_resp_valid is discarded (no push), go to REQ.
- HALT: no requests until redirect.
- Redirect, in any state, at the edge where it is sampled:
  - Buffer is flushed, including any push or pop in that cycle.
  - pc_advance is forced to 0 that cycle.
  - imem_req_valid is 0 that cycle. The next request is issued at the jump target, the cycle after redirect.
  - Next state: DROP if a response is outstanding and not arriving this cycle; otherwise REQ.
- Buffer:
  - Push lands at the edge, so inst_valid rises the cycle after the response.
  - Simultaneous push and pop while full is legal; the pop frees the slot that cycle.
  - Head fields are stable while inst_valid && !inst_ready.
- Latency: with zero-wait memory (response the cycle after accept), one instruction every 2 cycles. After reset release, the first request is at pc=0x8000_0000 in cycle 1.
- Decode stall: once FIFO_DEPTH entries are buffered or in flight, imem_req_valid stays low and pc_advance is never pulsed. The PC generator therefore holds and no PC value is skipped.
- Width: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-WAIT: the state is cleared. A late response arriving after reset in REQ is ignored, since outstanding=0.

Decomposition:
- Shared package holds:
  - state enum {REQ, WAIT, DROP, HALT}
  - RESET_PC = 32'h8000_0000
  - fetch-entry struct {pc, data, fault}
- Sub-module ifu_fifo: synchronous FIFO of fetch entries with push, pop and flush, exposing full, empty and count. Flush has priority over push and pop.

Test Plan:
- Reset release with zero-wait memory returning 0x00000013 → requests at 0x80000000, 0x80000004, 0x80000008; inst_valid every 2nd cycle with matching inst_pc; pc_advance once per accepted request.
- inst_ready held 0 → after 2 entries (FIFO_DEPTH=2), imem_req_valid=0 and pc_advance=0. Raise inst_ready → draining resumes in order with no PC skipped.
- redirect in WAIT for a request at 0x80000004 with target 0x80000100 → that response is dropped and the buffer flushed. The next request is at 0x80000100; the first inst_pc out is 0x80000100.
- redirect in the same cycle as a request-accept handshake → pc_advance=0, response dropped, next request at the jump target.
- imem_resp_err=1 at 0x80000008 → entry has inst_fault=1 and fetch continues at 0x8000000C. pc=0x80000102 → fault entry pushed and fetch halts until redirect.
- rst asserted in WAIT → all outputs 0 next cycle. A stale response after reset pushes nothing; the first request after release is at 0x80000000.
